// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receive path with even-parity checking,
// a show-ahead receive FIFO and sticky line-error status for the bus side.
module uart_receiver #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_FIFO  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 serial_data_in,
  input  logic                 read_data,
  input  logic                 clear_error,
  output logic [DATA_SIZE-1:0] bus_data,
  output logic [7:0]           status_register
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_SIZE + 1);
  localparam int AW = $clog2(SIZE_FIFO);

  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_SIZE - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(SIZE_FIFO);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_SIZE-1:0] shreg;
  logic                 perr;
  logic                 parity_error;
  logic                 frame_error;
  logic                 overrun_error;

  logic                 sync_meta;
  logic                 rx_s;

  logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 stop_tick;
  logic                 pop;
  logic                 push;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH);
  assign stop_tick  = (state == STOP) && (cnt == FULL_TICK);
  assign pop        = read_data && !fifo_empty;
  assign push       = stop_tick && rx_s && !perr && (!fifo_full || pop);

  assign bus_data        = mem[rd_ptr];
  assign status_register = {3'b000, overrun_error, frame_error, parity_error,
                            fifo_full, fifo_empty};

  // Two-flop synchronizer for the asynchronous RX line, idling high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= serial_data_in;
      rx_s      <= sync_meta;
    end
  end

  // Frame recovery FSM with sticky error flags; a new error wins over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      perr          <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (clear_error) begin
        parity_error  <= 1'b0;
        frame_error   <= 1'b0;
        overrun_error <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_TICK) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_TICK) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_SIZE-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (cnt == FULL_TICK) begin
            cnt   <= '0;
            perr  <= rx_s ^ (^shreg);
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_TICK) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end else begin
              state <= IDLE;
              if (perr) begin
                parity_error <= 1'b1;
              end else if (fifo_full && !pop) begin
                overrun_error <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Receive FIFO: push on a good stop sample, pop on a strobe while non-empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE_FIFO; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level reference model of the receiver (word queue
// plus sticky flags) checked against the DUT over directed and random frames.
module tb_uart_receiver;

  localparam int OS    = 16;
  localparam int DS    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset_n;
  logic          serial_data_in;
  logic          read_data;
  logic          clear_error;
  logic [DS-1:0] bus_data;
  logic [7:0]    status_register;

  int total;
  int bad;

  logic [DS-1:0] m_q [$];
  logic          m_perr;
  logic          m_ferr;
  logic          m_oerr;

  uart_receiver #(
    .DATA_SIZE (DS),
    .SIZE_FIFO (DEPTH),
    .OVERSAMPLE(OS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .serial_data_in (serial_data_in),
    .read_data      (read_data),
    .clear_error    (clear_error),
    .bus_data       (bus_data),
    .status_register(status_register)
  );

  // Free-running clock at the oversampling rate.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] model_status();
    return {3'b000, m_oerr, m_ferr, m_perr, (m_q.size() == DEPTH), (m_q.size() == 0)};
  endfunction

  function automatic logic [DS-1:0] model_head();
    if (m_q.size() == 0) return '0;
    return m_q[0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_oerr = 1'b0;
  endtask

  // Frame outcome from the word-level rules: framing, then parity, then overrun.
  task automatic model_frame(input logic [DS-1:0] data, input bit par_ok,
                             input bit stop_ok, input bit pop_same);
    if (!stop_ok) begin
      m_ferr = 1'b1;
    end else if (!par_ok) begin
      m_perr = 1'b1;
    end else begin
      if (pop_same && m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() == DEPTH) m_oerr = 1'b1;
      else m_q.push_back(data);
    end
  endtask

  // Drives one full frame; entered and left 1 ns after a rising edge.
  task automatic send_frame(input logic [DS-1:0] data, input logic par,
                            input logic stop);
    serial_data_in = 1'b0;
    repeat (OS) @(posedge clk);
    #1;
    for (int i = 0; i < DS; i++) begin
      serial_data_in = data[i];
      repeat (OS) @(posedge clk);
      #1;
    end
    serial_data_in = par;
    repeat (OS) @(posedge clk);
    #1;
    serial_data_in = stop;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic line_idle(input int bits);
    serial_data_in = 1'b1;
    repeat (bits * OS) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [DS-1:0] data, input bit par_ok,
                       input bit stop_ok, input int idle_bits);
    logic p;
    p = par_ok ? ^data : ~(^data);
    send_frame(data, p, stop_ok);
    model_frame(data, par_ok, stop_ok, 1'b0);
    if (idle_bits > 0) line_idle(idle_bits);
  endtask

  task automatic pop_word();
    read_data = 1'b1;
    @(posedge clk);
    #1;
    read_data = 1'b0;
    if (m_q.size() > 0) void'(m_q.pop_front());
  endtask

  task automatic do_clear();
    clear_error = 1'b1;
    @(posedge clk);
    #1;
    clear_error = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_oerr = 1'b0;
  endtask

  task automatic test_reset();
    serial_data_in = 1'b1;
    read_data      = 1'b0;
    clear_error    = 1'b0;
    reset_n        = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (status_register !== 8'h01) begin
      bad++;
      $display("[TB] FAIL reset_status: got %h want %h", status_register, 8'h01);
    end
    total++;
    if (bus_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_bus_data: got %h want %h", bus_data, 8'h00);
    end
    reset_n = 1'b1;
    repeat (2 * OS) @(posedge clk);
    #1;
    total++;
    if (status_register !== model_status()) begin
      bad++;
      $display("[TB] FAIL post_reset_status: got %h want %h", status_register, model_status());
    end
  endtask

  task automatic test_single_frame();
    logic [DS-1:0] d;
    d = 8'hA5;
    fork
      send_frame(d, ^d, 1'b1);
      begin
        @(posedge clk);
        repeat (169) @(posedge clk);
        #1;
        total++;
        if (status_register[0] !== 1'b1) begin
          bad++;
          $display("[TB] FAIL latency_still_empty: got %b want %b", status_register[0], 1'b1);
        end
        @(posedge clk);
        #1;
        total++;
        if (status_register[0] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL latency_empty_falls: got %b want %b", status_register[0], 1'b0);
        end
        total++;
        if (bus_data !== 8'hA5) begin
          bad++;
          $display("[TB] FAIL single_data: got %h want %h", bus_data, 8'hA5);
        end
        total++;
        if (status_register !== 8'h00) begin
          bad++;
          $display("[TB] FAIL single_status: got %h want %h", status_register, 8'h00);
        end
      end
    join
    model_frame(d, 1'b1, 1'b1, 1'b0);
    line_idle(1);
    pop_word();
    total++;
    if (status_register !== 8'h01) begin
      bad++;
      $display("[TB] FAIL single_after_pop: got %h want %h", status_register, 8'h01);
    end
  endtask

  task automatic test_parity_error();
    frame(8'h3C, 1'b0, 1'b1, 1);
    total++;
    if (status_register !== 8'h05) begin
      bad++;
      $display("[TB] FAIL parity_status: got %h want %h", status_register, 8'h05);
    end
    do_clear();
    total++;
    if (status_register !== 8'h01) begin
      bad++;
      $display("[TB] FAIL parity_clear: got %h want %h", status_register, 8'h01);
    end
  endtask

  task automatic test_framing_break();
    frame(8'h55, 1'b1, 1'b0, 0);
    repeat (50 * OS) @(posedge clk);
    #1;
    total++;
    if (status_register !== 8'h09) begin
      bad++;
      $display("[TB] FAIL break_status: got %h want %h", status_register, 8'h09);
    end
    line_idle(2);
    frame(8'h12, 1'b1, 1'b1, 1);
    total++;
    if (bus_data !== 8'h12) begin
      bad++;
      $display("[TB] FAIL after_break_data: got %h want %h", bus_data, 8'h12);
    end
    total++;
    if (status_register !== 8'h08) begin
      bad++;
      $display("[TB] FAIL after_break_status: got %h want %h", status_register, 8'h08);
    end
    pop_word();
    do_clear();
    total++;
    if (status_register !== model_status()) begin
      bad++;
      $display("[TB] FAIL break_cleanup: got %h want %h", status_register, model_status());
    end
  endtask

  task automatic test_false_start();
    serial_data_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    serial_data_in = 1'b1;
    repeat (3 * OS) @(posedge clk);
    #1;
    total++;
    if (status_register !== 8'h01) begin
      bad++;
      $display("[TB] FAIL glitch_status: got %h want %h", status_register, 8'h01);
    end
    frame(8'h3A, 1'b1, 1'b1, 1);
    total++;
    if (bus_data !== 8'h3A || status_register !== 8'h00) begin
      bad++;
      $display("[TB] FAIL glitch_next_frame: got %h/%h want %h/%h", bus_data, status_register, 8'h3A, 8'h00);
    end
    pop_word();
  endtask

  task automatic test_fill_overrun();
    for (int w = 0; w < DEPTH; w++) frame(8'(w), 1'b1, 1'b1, 0);
    line_idle(1);
    total++;
    if (status_register !== 8'h02) begin
      bad++;
      $display("[TB] FAIL fill_full: got %h want %h", status_register, 8'h02);
    end
    frame(8'h08, 1'b1, 1'b1, 1);
    total++;
    if (status_register !== 8'h12) begin
      bad++;
      $display("[TB] FAIL overrun_status: got %h want %h", status_register, 8'h12);
    end
    for (int w = 0; w < DEPTH; w++) begin
      total++;
      if (bus_data !== 8'(w)) begin
        bad++;
        $display("[TB] FAIL fill_order[%0d]: got %h want %h", w, bus_data, 8'(w));
      end
      pop_word();
    end
    total++;
    if (status_register !== 8'h11) begin
      bad++;
      $display("[TB] FAIL drained_status: got %h want %h", status_register, 8'h11);
    end
    pop_word();
    total++;
    if (status_register !== 8'h11) begin
      bad++;
      $display("[TB] FAIL underflow_ignored: got %h want %h", status_register, 8'h11);
    end
    do_clear();
  endtask

  task automatic test_push_pop_full();
    logic [DS-1:0] d;
    logic [DS-1:0] last;
    d = 8'h99;
    last = '0;
    for (int w = 0; w < DEPTH; w++) frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 0);
    line_idle(1);
    fork
      send_frame(d, ^d, 1'b1);
      begin
        @(posedge clk);
        repeat (169) @(posedge clk);
        #1;
        read_data = 1'b1;
        @(posedge clk);
        #1;
        read_data = 1'b0;
      end
    join
    model_frame(d, 1'b1, 1'b1, 1'b1);
    line_idle(1);
    total++;
    if (status_register !== 8'h02) begin
      bad++;
      $display("[TB] FAIL pushpop_full_status: got %h want %h", status_register, 8'h02);
    end
    for (int w = 0; w < DEPTH; w++) begin
      total++;
      if (bus_data !== model_head()) begin
        bad++;
        $display("[TB] FAIL pushpop_order[%0d]: got %h want %h", w, bus_data, model_head());
      end
      last = bus_data;
      pop_word();
    end
    total++;
    if (last !== 8'h99) begin
      bad++;
      $display("[TB] FAIL pushpop_last: got %h want %h", last, 8'h99);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame(8'h5A, 1'b1, 1'b1, 1);
    serial_data_in = 1'b0;
    repeat (OS) @(posedge clk);
    #1;
    serial_data_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (status_register !== 8'h01) begin
      bad++;
      $display("[TB] FAIL midreset_status: got %h want %h", status_register, 8'h01);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    line_idle(2);
    frame(8'hC3, 1'b1, 1'b1, 1);
    total++;
    if (bus_data !== 8'hC3 || status_register !== 8'h00) begin
      bad++;
      $display("[TB] FAIL midreset_next: got %h/%h want %h/%h", bus_data, status_register, 8'hC3, 8'h00);
    end
    pop_word();
  endtask

  task automatic test_random();
    int kind;
    int pops;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      frame(8'($urandom_range(0, 255)), kind != 0, kind != 1, 1);
      total++;
      if (status_register !== model_status()) begin
        bad++;
        $display("[TB] FAIL rand_status[%0d]: got %h want %h", it, status_register, model_status());
      end
      pops = $urandom_range(0, 2);
      for (int p = 0; p < pops; p++) begin
        if (m_q.size() > 0) begin
          total++;
          if (bus_data !== model_head()) begin
            bad++;
            $display("[TB] FAIL rand_data[%0d]: got %h want %h", it, bus_data, model_head());
          end
        end
        pop_word();
      end
      if ($urandom_range(0, 4) == 0) do_clear();
      total++;
      if (status_register !== model_status()) begin
        bad++;
        $display("[TB] FAIL rand_after_pop[%0d]: got %h want %h", it, status_register, model_status());
      end
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_frame();
    test_parity_error();
    test_framing_break();
    test_false_start();
    test_fill_overrun();
    test_push_pop_full();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the UART, directly downstream of the transmitter: it consumes the serial stream that the transmitter drives. It oversamples the line, recovers frames of start, DATA_SIZE data bits LSB first, even parity and one stop bit. Good words are buffered in an internal FIFO, and the block reports FIFO and line-error status to the bus side.

## Interface
- DATA_SIZE, 8: data bits per frame.
- SIZE_FIFO, 8: receive FIFO depth in words; power of two, at least 2.
- OVERSAMPLE, 16: clk cycles per bit; even, at least 4.
- clk  input  1  single clock, running at OVERSAMPLE × bit rate; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- serial_data_in  input  1  asynchronous RX line; idles high.
- read_data  input  1  one-cycle pop strobe for the FIFO head.
- clear_error  input  1  clears the sticky error bits.
- bus_data  output  DATA_SIZE  FIFO head word (show-ahead); meaningful only while empty=0.
- status_register  output  8  {3'b0, overrun_error, frame_error, parity_error, full, empty}.

## Operation
- Input sync: serial_data_in passes through 2 flops (reset to 1) to give rx_s. The FSM uses only rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Sample counter cnt is cleared on every state entry and after every sample.
- IDLE: when rx_s=0, go to START with cnt=0.
- START: at cnt==OVERSAMPLE/2-1, sample rx_s.
  - 0: go to DATA.
  - 1: false start; go to IDLE with no flags set.
- DATA: sample at cnt==OVERSAMPLE-1.
  - Shift the sample into shreg from the MSB side, so bit 0 is received first.
  - After DATA_SIZE samples, go to PARITY.
- PARITY: sample at cnt==OVERSAMPLE-1.
  - Set perr = sample XOR (^shreg). Even parity over data plus parity bit, matching the transmitter.
  - Go to STOP.
- STOP: sample at cnt==OVERSAMPLE-1. Exactly one outcome applies:
  - Sample 0: set frame_error, drop the word, go to WAIT_IDLE.
  - Sample 1, perr=1: set parity_error, drop the word, go to IDLE.
  - Sample 1, perr=0, FIFO full and no pop this cycle: set overrun_error, drop the word, go to IDLE.
  - Otherwise: push shreg into the FIFO, go to IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This covers break and a stuck-low line.
- FIFO: single-clock, SIZE_FIFO entries.
  - Pointers are $clog2(SIZE_FIFO) bits and wrap naturally.
  - Occupancy count is $clog2(SIZE_FIFO)+1 bits.
  - empty = (count==0); full = (count==SIZE_FIFO).
- Pop: read_data while empty=1 is ignored; there is no underflow flag and pointers do not move.
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - Allowed when full, so no overrun is flagged.
  - When empty, only the push occurs.
- Error bits are sticky and set on the cycle of the STOP sample. clear_error clears all three.
- If clear_error and a new error event occur in the same cycle, set wins.
- Reset mid-frame: the frame is discarded, the FSM returns to IDLE, and the FIFO is emptied.

## Timing
- Reset values:
  - FSM in IDLE; cnt=0; shreg=0; sync flops=1.
  - FIFO empty; bus_data=0; status_register=8'h01.
- Let edge E0 be the first clk edge that captures serial_data_in=0.
  - The FSM enters START at E2.
  - Start sample at E10; data bit k sampled at E26+16k (for OVERSAMPLE=16).
  - Parity sample at E154; stop sample at E170.
- Push takes effect at the stop-sample edge. empty falls and bus_data is valid in the cycle after E170.
- Pop: bus_data shows the next word in the cycle after the read_data edge.
- The FSM returns to IDLE at the stop-sample edge. A start bit immediately after the stop bit is therefore detected with no lost cycles.
- Status bits are registered and change one edge after their cause.

## Test plan
- Single frame, 0xA5 (parity 0, stop 1), OVERSAMPLE=16:
  - empty 1→0 exactly 170 cycles after the capture edge; bus_data=0xA5; status=8'h00.
  - One read_data → status=8'h01.
- Parity error, 0x3C sent with parity 1:
  - status = 8'h05 (parity_error and empty set); FIFO stays empty.
  - clear_error → status = 8'h01.
- Framing and break:
  - 0x55 with stop=0 → frame_error set; FSM holds in WAIT_IDLE while the line stays low for 50 bit times; nothing is pushed.
  - Line high, then frame 0x12 → received correctly.
- False start: a 4-cycle low glitch → no push, no error flags, FSM back in IDLE.
- Fill and overrun:
  - 8 back-to-back frames 0x00–0x07 → full=1.
  - 9th frame 0x08 with no read → overrun_error=1, word dropped.
  - Read-out order 0x00–0x07, then empty=1.
- Simultaneous push/pop when full: FIFO full, read_data on the stop-sample edge of frame 0x99 → full stays 1, no overrun, and 0x99 is last in the read-out order.
- Reset mid-frame: assert reset_n low during DATA → status=8'h01 at once; the next clean frame 0xC3 is received correctly.
